// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment scanner.
package sseg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam int REFRESH_DIV_DEFAULT = 100000;

  typedef logic [1:0] digit_sel_t;

  // Active-low one-hot anode pattern for a selected digit.
  function automatic logic [3:0] an_for_sel(input digit_sel_t sel);
    return ~(4'b0001 << sel);
  endfunction

endpackage

// File: rtl/sseg_prescaler.sv
// Refresh prescaler: counts 0..REFRESH_DIV-1 and pulses tick on the last count.
module sseg_prescaler
  import sseg_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sseg_scan_mux.sv
// Four-digit seven-segment scanner with frame-aligned value updates.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank,
  output logic [3:0]  hex,
  output logic        dp,
  output logic [3:0]  an,
  output logic        load_pending
);

  logic       tick;
  logic       frame_end;
  digit_sel_t sel_q, sel_d;
  logic [15:0] disp_data_q, disp_data_d;
  logic [3:0]  disp_dp_q, disp_dp_d;
  logic [15:0] shadow_data_q, shadow_data_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;
  logic        pending_q, pending_d;
  logic [3:0]  an_q, an_d;
  logic [3:0]  hex_q, hex_d;
  logic        dp_q, dp_d;
  logic [3:0]  suppress;
`ifdef LEADING_ZERO_BLANK_EN
  logic        lz_run;
`endif

  sseg_prescaler #(.REFRESH_DIV(REFRESH_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Digit select and the shadow/display register handoff at the frame boundary.
  always_comb begin
    frame_end     = tick && (sel_q == digit_sel_t'(NUM_DIGITS - 1));
    sel_d         = tick ? sel_q + digit_sel_t'(1) : sel_q;
    disp_data_d   = disp_data_q;
    disp_dp_d     = disp_dp_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    pending_d     = pending_q;
    if (frame_end) begin
      if (load) begin
        disp_data_d = data_in;
        disp_dp_d   = dp_in;
      end else if (pending_q) begin
        disp_data_d = shadow_data_q;
        disp_dp_d   = shadow_dp_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      shadow_data_d = data_in;
      shadow_dp_d   = dp_in;
      pending_d     = 1'b1;
    end
  end

  // A digit is suppressed while it and all higher digits are zero with no decimal point set.
  always_comb begin
    suppress = '0;
`ifdef LEADING_ZERO_BLANK_EN
    lz_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lz_run      = lz_run && (disp_data_q[4*k +: 4] == 4'h0) && !disp_dp_q[k];
      suppress[k] = lz_run;
    end
`endif
  end

  always_comb begin
    hex_d = disp_data_q[{sel_q, 2'b00} +: 4];
    dp_d  = blank ? 1'b1 : ~disp_dp_q[sel_q];
    an_d  = (blank || suppress[sel_q]) ? AN_OFF : an_for_sel(sel_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q         <= '0;
      disp_data_q   <= '0;
      disp_dp_q     <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      pending_q     <= 1'b0;
      an_q          <= AN_OFF;
      hex_q         <= 4'h0;
      dp_q          <= 1'b1;
    end else begin
      sel_q         <= sel_d;
      disp_data_q   <= disp_data_d;
      disp_dp_q     <= disp_dp_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      pending_q     <= pending_d;
      an_q          <= an_d;
      hex_q         <= hex_d;
      dp_q          <= dp_d;
    end
  end

  assign an           = an_q;
  assign hex          = hex_q;
  assign dp           = dp_q;
  assign load_pending = pending_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Randomised and directed bench for sseg_scan_mux with a cycle-level reference model.
module tb_sseg_scan_mux;

  localparam int DIV = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank;
  logic [3:0]  hex;
  logic        dp;
  logic [3:0]  an;
  logic        load_pending;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: edges since reset, displayed/pending values.
  int          n;
  logic [15:0] m_disp, m_shadow;
  logic [3:0]  m_dp, m_shadow_dp;
  logic        m_pend;
  logic [3:0]  exp_an, exp_hex;
  logic        exp_dp;

  sseg_scan_mux #(.REFRESH_DIV(DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .dp_in        (dp_in),
    .load         (load),
    .blank        (blank),
    .hex          (hex),
    .dp           (dp),
    .an           (an),
    .load_pending (load_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %h, expected %h", tag, n, obs, exp);
    end
  endtask

  // Highest digit that must be lit; digits above it are suppressed.
  function automatic int lit_top(input logic [15:0] v, input logic [3:0] d);
`ifdef LEADING_ZERO_BLANK_EN
    for (int k = 3; k >= 1; k--)
      if (((v >> (4 * k)) & 16'hF) != 0 || d[k]) return k;
    return 0;
`else
    return 3;
`endif
  endfunction

  // One clock: the model consumes the inputs present at the edge, then outputs are compared.
  task automatic step();
    int s;
    @(posedge clk);
    if (reset) begin
      n = 0; m_disp = '0; m_dp = '0; m_shadow = '0; m_shadow_dp = '0; m_pend = 1'b0;
      exp_an = 4'hF; exp_hex = 4'h0; exp_dp = 1'b1;
    end else begin
      s       = (n / DIV) % 4;
      exp_hex = 4'((m_disp >> (4 * s)) & 16'hF);
      exp_dp  = blank ? 1'b1 : !m_dp[s];
      exp_an  = (blank || s > lit_top(m_disp, m_dp)) ? 4'hF : (4'hF ^ 4'(1 << s));
      if ((n + 1) % FRAME == 0) begin
        if (load) begin m_disp = data_in; m_dp = dp_in; end
        else if (m_pend) begin m_disp = m_shadow; m_dp = m_shadow_dp; end
        m_pend = 1'b0;
      end else if (load) begin
        m_shadow = data_in; m_shadow_dp = dp_in; m_pend = 1'b1;
      end
      n++;
    end
    #1;
    chk("an", 16'(an), 16'(exp_an));
    chk("hex", 16'(hex), 16'(exp_hex));
    chk("dp", 16'(dp), 16'(exp_dp));
    chk("load_pending", 16'(load_pending), 16'(m_pend));
  endtask

  task automatic idle(input int cycles);
    load = 1'b0;
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    data_in = v; dp_in = d; load = 1'b1;
    step();
    load = 1'b0; data_in = $urandom; dp_in = 4'($urandom);
  endtask

  initial begin
    n = 0;
    reset = 1'b1; load = 1'b0; blank = 1'b0; data_in = '0; dp_in = '0;
    step(); step(); step();
    reset = 1'b0;

    // Idle frame after reset: zeros on every digit.
    idle(FRAME);

    // Mid-frame load shows only after the boundary.
    idle(5);
    do_load(16'hA5C3, 4'b0100);
    idle(2 * FRAME + 3);

    // Two loads in one frame: last wins.
    while (n % FRAME != 2) idle(1);
    do_load(16'h1111, 4'b0001);
    idle(4);
    do_load(16'h2222, 4'b0000);
    idle(2 * FRAME);

    // Load on the boundary cycle itself.
    while (n % FRAME != FRAME - 1) idle(1);
    do_load(16'h7E19, 4'b1000);
    idle(FRAME + 2);

    // Blank for six cycles mid-frame.
    idle(3);
    blank = 1'b1;
    idle(6);
    blank = 1'b0;
    idle(FRAME);

    // Leading-zero pattern, and a dp exemption on it.
    do_load(16'h0042, 4'b0000);
    idle(2 * FRAME);
    do_load(16'h0005, 4'b0100);
    idle(2 * FRAME);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      load    = ($urandom_range(0, 11) == 0);
      data_in = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      dp_in   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 19) == 0) blank = ~blank;
      step();
    end
    load = 1'b0; blank = 1'b0;

    // Reset mid-frame with a load pending.
    idle(7);
    do_load(16'hBEEF, 4'b1111);
    idle(2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle(FRAME + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
